// File: rtl/freq_div_prog_if.sv
// Control and output bundle of the programmable multi-channel clock divider.
// The master drives the enables, SYNC and the shadow-load port. The slave returns the divided clocks and ticks.
interface freq_div_prog_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] EN;
    logic              SYNC;
    logic              LOAD;
    logic [SEL_W-1:0]  LOAD_SEL;
    logic [CNT_W-1:0]  DIV_IN;
    logic [NUM_CH-1:0] CLK_OUT;
    logic [NUM_CH-1:0] TICK;

    modport master (
        output EN, SYNC, LOAD, LOAD_SEL, DIV_IN,
        input  CLK_OUT, TICK
    );

    modport slave (
        input  EN, SYNC, LOAD, LOAD_SEL, DIV_IN,
        output CLK_OUT, TICK
    );
endinterface

// File: rtl/freq_div_prog.sv
// Multi-channel, run-time programmable 50%-duty clock divider with a rise tick per channel.
// A new half-period count passes through a shadow register and takes effect only at a toggle boundary.
module freq_div_prog #(
    parameter int                      NUM_CH = 3,
    parameter int                      CNT_W  = 8,
    parameter logic [NUM_CH*CNT_W-1:0] INIT_H = {8'd50, 8'd5, 8'd1}
) (
    input  logic                 CLK_in,
    input  logic                 RST,
    freq_div_prog_if.slave       bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNT_W-1:0]  h_act_q [NUM_CH];
    logic [CNT_W-1:0]  h_act_d [NUM_CH];
    logic [CNT_W-1:0]  h_shd_q [NUM_CH];
    logic [CNT_W-1:0]  h_shd_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] load_hit;

    // A select value of NUM_CH or more matches no channel, so the load is dropped.
    always_comb begin
        load_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_hit[i] = bus.LOAD && (bus.LOAD_SEL == SEL_W'(i));
        end
    end

    always_comb begin
        h_act_d   = h_act_q;
        h_shd_d   = h_shd_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_hit[i]) begin
                h_shd_d[i] = bus.DIV_IN;
            end
            if (bus.SYNC) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                h_act_d[i]   = h_shd_d[i];
            end else if (h_act_q[i] == '0) begin
                // Parked: keep polling the shadow so a nonzero load restarts the channel.
                cnt_d[i]   = '0;
                h_act_d[i] = h_shd_q[i];
            end else if (bus.EN[i]) begin
                if (cnt_q[i] == h_act_q[i] - CNT_W'(1)) begin
                    clk_out_d[i] = ~clk_out_q[i];
                    tick_d[i]    = ~clk_out_q[i];
                    cnt_d[i]     = '0;
                    h_act_d[i]   = h_shd_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                h_act_q[i] <= INIT_H[i*CNT_W +: CNT_W];
                h_shd_q[i] <= INIT_H[i*CNT_W +: CNT_W];
                cnt_q[i]   <= '0;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            h_act_q   <= h_act_d;
            h_shd_q   <= h_shd_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.CLK_OUT = clk_out_q;
    assign bus.TICK    = tick_q;
endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog covering reset defaults, glitch-free reload, EN gating,
// SYNC with a same-cycle load, park/unpark, an ignored out-of-range select and a mid-run reset.
module tb_freq_div_prog;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    freq_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    freq_div_prog #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .INIT_H ({8'd50, 8'd5, 8'd1})
    ) dut (
        .CLK_in (clk_in),
        .RST    (rst),
        .bus    (bus)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Level of a free-running divider with half-period h, j enabled edges after a restart.
    function automatic logic ph(input int j, input int h);
        return ((j / h) % 2) == 1;
    endfunction

    function automatic logic tk(input int j, input int h);
        return (j > 0) && ((j % (2 * h)) == h);
    endfunction

    function automatic logic reld_ch1(input int k);
        if (k < 205) return 1'b0;
        if (k < 210) return 1'b1;
        if (k < 213) return 1'b0;
        if (k < 216) return 1'b1;
        if (k < 219) return 1'b0;
        if (k < 222) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic park_ch1(input int j);
        if (j < 243) return 1'b0;
        if (j < 264) return 1'b1;
        return ((j - 262) / 2) % 2 == 0;
    endfunction

    function automatic logic park_tk1(input int j);
        return (j == 243) || (j >= 266 && ((j - 262) % 4) == 0);
    endfunction

    initial begin
        bus.EN       = '0;
        bus.SYNC     = 1'b0;
        bus.LOAD     = 1'b0;
        bus.LOAD_SEL = '0;
        bus.DIV_IN   = '0;

        // Reset defaults: legacy /2, /10, /100.
        rst = 1'b1;
        cyc();
        cyc();
        check_eq("rst_clk", 8'(bus.CLK_OUT), 8'h00);
        check_eq("rst_tick", 8'(bus.TICK), 8'h00);
        rst    = 1'b0;
        bus.EN = 3'b111;
        for (int k = 1; k <= 200; k++) begin
            cyc();
            check_eq("dflt_clk", 8'(bus.CLK_OUT), 8'({ph(k, 50), ph(k, 5), ph(k, 1)}));
            check_eq("dflt_tick", 8'(bus.TICK), 8'({tk(k, 50), tk(k, 5), tk(k, 1)}));
        end

        // Reload ch1 to 3 at cnt=1 of the high phase that starts at edge 205.
        for (int k = 201; k <= 223; k++) begin
            bus.LOAD     = (k == 207);
            bus.LOAD_SEL = 2'd1;
            bus.DIV_IN   = 8'd3;
            cyc();
            check_eq("reld_clk1", 8'(bus.CLK_OUT[1]), 8'(reld_ch1(k)));
            check_eq("reld_tick1", 8'(bus.TICK[1]), 8'((k == 205) || (k == 213) || (k == 219)));
            check_eq("reld_clk0", 8'(bus.CLK_OUT[0]), 8'(ph(k, 1)));
        end
        check_eq("pre_sync_clk0", 8'(bus.CLK_OUT[0]), 8'h01);

        // SYNC with a same-cycle load of 4 into ch0.
        bus.SYNC     = 1'b1;
        bus.LOAD     = 1'b1;
        bus.LOAD_SEL = 2'd0;
        bus.DIV_IN   = 8'd4;
        cyc();
        bus.SYNC = 1'b0;
        bus.LOAD = 1'b0;
        check_eq("sync_clk", 8'(bus.CLK_OUT), 8'h00);
        check_eq("sync_tick", 8'(bus.TICK), 8'h00);
        for (int j = 1; j <= 120; j++) begin
            cyc();
            check_eq("sync_run_clk", 8'(bus.CLK_OUT), 8'({ph(j, 50), ph(j, 3), ph(j, 4)}));
            check_eq("sync_run_tick", 8'(bus.TICK), 8'({tk(j, 50), tk(j, 3), tk(j, 4)}));
        end

        // EN[2] low for 7 cycles mid low-phase of ch2 (cnt=20).
        for (int j = 121; j <= 240; j++) begin
            bus.EN = (j <= 127) ? 3'b011 : 3'b111;
            cyc();
            check_eq("gate_clk", 8'(bus.CLK_OUT), 8'({ph(j - 7, 50), ph(j, 3), ph(j, 4)}));
            check_eq("gate_tick", 8'(bus.TICK), 8'({tk(j - 7, 50), tk(j, 3), tk(j, 4)}));
        end

        // Park ch1 with a load of 0, unpark with 2, then an out-of-range select.
        for (int j = 241; j <= 300; j++) begin
            bus.LOAD     = (j == 241) || (j == 261) || (j == 280);
            bus.LOAD_SEL = (j == 280) ? 2'd3 : 2'd1;
            bus.DIV_IN   = (j == 241) ? 8'd0 : ((j == 261) ? 8'd2 : 8'd7);
            cyc();
            check_eq("park_clk", 8'(bus.CLK_OUT), 8'({ph(j - 7, 50), park_ch1(j), ph(j, 4)}));
            check_eq("park_tick", 8'(bus.TICK), 8'({tk(j - 7, 50), park_tk1(j), tk(j, 4)}));
        end
        bus.LOAD = 1'b0;
        check_eq("pre_rst_clk2", 8'(bus.CLK_OUT[2]), 8'h01);

        // Reset mid-run: the loaded ch0 count of 4 must be discarded.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("mrst_clk", 8'(bus.CLK_OUT), 8'h00);
        check_eq("mrst_tick", 8'(bus.TICK), 8'h00);
        for (int k = 1; k <= 110; k++) begin
            cyc();
            check_eq("mrst_run_clk", 8'(bus.CLK_OUT), 8'({ph(k, 50), ph(k, 5), ph(k, 1)}));
            check_eq("mrst_run_tick", 8'(bus.TICK), 8'({tk(k, 50), tk(k, 5), tk(k, 1)}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
- Multi-channel, run-time programmable clock divider. Successor to the fixed /2, /10, /100 divider.
- Each channel produces a 50%-duty divided output of CLK_in, plus a one-cycle tick on each output rising edge.
- Half-period counts are loadable on the fly. A new count takes effect glitch-free at the next toggle boundary.
- A global SYNC re-phases all channels. Reset defaults reproduce the legacy /2, /10, /100 outputs.

Parameters:
- NUM_CH, 3: number of divider channels (1..16).
- CNT_W, 8: width of each half-period count and counter.
- INIT_H, {8'd50,8'd5,8'd1}: packed NUM_CH*CNT_W reset half-period counts. Channel i uses bits [i*CNT_W +: CNT_W].

Ports:
- CLK_in  input  1  input clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  NUM_CH  per-channel count enable.
- SYNC  input  1  single-cycle pulse: re-phase all channels.
- LOAD  input  1  write DIV_IN to the shadow count of channel LOAD_SEL.
- LOAD_SEL  input  $clog2(NUM_CH) (min 1)  target channel index.
- DIV_IN  input  CNT_W  new half-period count H.
- CLK_OUT  output  NUM_CH  divided clocks (registered).
- TICK  output  NUM_CH  one-cycle pulse, high in the same cycle CLK_OUT[i] goes 0->1.

Behaviour:
- Per-channel state: h_act (active H), h_shd (shadow H), cnt (CNT_W bits), CLK_OUT[i], TICK[i].
- Output period is 2*H enabled CLK_in cycles with 50% duty (high H cycles, low H cycles).
- RST (synchronous; highest priority): h_act = h_shd = INIT_H slice, cnt = 0, CLK_OUT = 0, TICK = 0.
- LOAD: h_shd[LOAD_SEL] <= DIV_IN. A LOAD_SEL value >= NUM_CH is ignored. h_act is not changed directly by LOAD.
- SYNC (priority over EN): for all channels, cnt <= 0, CLK_OUT <= 0, TICK <= 0, h_act <= h_shd.
  - If LOAD occurs in the same cycle as SYNC, the loaded channel takes DIV_IN as both h_shd and h_act.
- Normal cycle, EN[i]=1, h_act != 0:
  - If cnt == h_act-1: CLK_OUT toggles, cnt <= 0, h_act <= h_shd. TICK <= 1 if CLK_OUT goes 0->1, else 0.
  - Otherwise: cnt <= cnt+1, TICK <= 0.
- EN[i]=0: cnt and CLK_OUT hold, TICK <= 0. The shadow still accepts LOAD.
- h_act == 0 (channel parked):
  - cnt held at 0, CLK_OUT holds its level, TICK = 0.
  - h_act <= h_shd every cycle, so the channel restarts one cycle after a nonzero load.
- A load of 0 therefore parks the channel at its next toggle boundary, with the output frozen at the post-toggle level.
- Latency from reset release with EN=1:
  - H=1: CLK_OUT rises on the 1st edge after RST low.
  - H=5: CLK_OUT rises on the 5th edge and falls on the 10th.
- Wrap: cnt never exceeds h_act-1. Maximum H is 2^CNT_W-1, giving period 2*(2^CNT_W-1).
- Reprogramming mid-half-period never shortens or lengthens the current half-period. No runt pulses.
- A LOAD to the same channel in consecutive cycles: last write wins.

Test Plan:
- Reset defaults: RST 2 cycles, then EN=3'b111 for 200 cycles. CLK_OUT[0] period 2, CLK_OUT[1] period 10, CLK_OUT[2] period 100, all 50% duty; first rises on edges 1, 5, 50 after reset; TICK coincides with each rise.
- Glitch-free reload: ch1 running H=5; LOAD ch1 DIV_IN=3 at cnt=1 of a high phase. The high phase still lasts 5 cycles; the following phases last 3.
- EN gating: drop EN[2] for 7 cycles mid-phase. CLK_OUT[2] and cnt freeze and TICK stays 0; resuming adds exactly 7 cycles to that phase.
- SYNC with simultaneous LOAD ch0 DIV_IN=4: all outputs 0 the next cycle; ch0 rises 4 edges later with period 8; ch1 and ch2 restart from cnt 0.
- Park/unpark: LOAD ch1 DIV_IN=0. The output freezes after the next toggle; a later LOAD of 2 restarts ch1 with period 4 starting one cycle later. LOAD_SEL=3 (NUM_CH=3) changes nothing.
- Reset mid-operation: assert RST while CLK_OUT=1 and cnt nonzero. The next cycle has all outputs 0 and h_act at INIT_H; a previously loaded shadow is discarded.
